// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator: one phase accumulator per channel,
// ce pulses on accumulator carry, with a lock counter that qualifies the outputs.
module clk_en_gen #(
  parameter int NCH           = 4,
  parameter int ACC_W         = 32,
  parameter int LOCK_CYCLES   = 1024,
  parameter int GATE_UNLOCKED = 1
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [3:0]       wr_ch,
  input  logic [ACC_W-1:0] wr_data,
  input  logic             resync,
  input  logic [3:0]       rd_ch,
  output logic [ACC_W-1:0] rd_data,
  output logic [NCH-1:0]   ce,
  output logic             locked
);

  localparam int   CW   = $clog2(LOCK_CYCLES + 1);
  localparam logic GATE = (GATE_UNLOCKED != 0);

  logic [ACC_W-1:0] inc_reg [NCH];
  logic [ACC_W-1:0] acc_reg [NCH];
  logic             ce_reg  [NCH];
  logic [NCH-1:0]   wr_hit;
  logic             wr_accept;
  logic [CW-1:0]    lock_cnt_reg;
  logic [ACC_W-1:0] rd_data_reg;
  logic [ACC_W-1:0] rd_mux;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      // Channel indices >= NCH never match, so out-of-range writes fall through untouched.
      assign wr_hit[gi] = wr_en && (wr_ch == 4'(gi));

      always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
          inc_reg[gi] <= '0;
          acc_reg[gi] <= '0;
          ce_reg[gi]  <= 1'b0;
        end else if (wr_hit[gi]) begin
          inc_reg[gi] <= wr_data;
          acc_reg[gi] <= '0;
          ce_reg[gi]  <= 1'b0;
        end else if (resync) begin
          acc_reg[gi] <= '0;
          ce_reg[gi]  <= 1'b0;
        end else begin
          {ce_reg[gi], acc_reg[gi]} <= {1'b0, acc_reg[gi]} + {1'b0, inc_reg[gi]};
        end
      end

      assign ce[gi] = ce_reg[gi] & (locked | ~GATE);
    end
  endgenerate

  assign wr_accept = |wr_hit;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_reg <= '0;
    end else if (wr_accept || resync) begin
      lock_cnt_reg <= '0;
    end else if (lock_cnt_reg != CW'(LOCK_CYCLES)) begin
      lock_cnt_reg <= lock_cnt_reg + CW'(1);
    end
  end

  assign locked = (lock_cnt_reg == CW'(LOCK_CYCLES));

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NCH; c++) begin
      if (rd_ch == 4'(c)) rd_mux = inc_reg[c];
    end
  end

  // Reads the pre-write increment, so a same-cycle write shows up one cycle later.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) rd_data_reg <= '0;
    else        rd_data_reg <= rd_mux;
  end

  assign rd_data = rd_data_reg;

endmodule
